dpram_port_arbiter: RTL and testbench

- Shares the two ports of the team's single-clock dual-port RAM between N_REQ independent requesters.
- Each cycle it grants up to two requests, round-robin. The first winner goes to RAM port A and the second to port B.
- It drives the RAM's per-port write enables, clock enable, addresses and write data.
- It routes the registered RAM read data back to the requester that issued the read, one cycle after grant.
- It sits between client logic and the RAM instance; clients never touch the RAM directly.

---
 rtl/dpram_arb_pkg.sv | 18 +
 rtl/dpram_port_arbiter_rr_pick.sv | 34 +++
 rtl/dpram_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dpram_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_arb_pkg.sv
// Shared constants, port selector type and index-width helper for the DP-RAM port arbiter.
package dpram_arb_pkg;

  localparam int unsigned N_REQ_DEF      = 4;
  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ADDR_WIDTH_DEF = 3;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dpram_port_arbiter_rr_pick.sv
// Round-robin picker: first set bit of (req & mask) at or after ptr, wrapping.
module rr_pick
  import dpram_arb_pkg::*;
#(
  parameter  int unsigned N_REQ = N_REQ_DEF,
  localparam int unsigned IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [N_REQ-1:0] i_mask,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  logic [N_REQ-1:0] w_cand;

  assign w_cand = i_req & i_mask;

  // Scan from the farthest offset back to ptr so the nearest candidate is written last.
  always_comb begin
    int unsigned pos;
    pos     = 0;
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = (32'(i_ptr) + 32'(k)) % N_REQ;
      if (w_cand[IDX_W'(pos)]) begin
        o_found = 1'b1;
        o_idx   = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Shares both ports of a single-clock dual-port RAM between N_REQ requesters,
// granting up to two requests per cycle round-robin and routing read data back.
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter  int unsigned N_REQ      = N_REQ_DEF,
  localparam int unsigned IDX_W      = idx_width(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            we,
  input  logic [N_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            rvalid,
  output logic [N_REQ*DATA_WIDTH-1:0] rdata,
  output logic                        ram_ce,
  output logic                        ram_we_a,
  output logic                        ram_we_b,
  output logic [ADDR_WIDTH-1:0]       ram_addr_a,
  output logic [ADDR_WIDTH-1:0]       ram_addr_b,
  output logic [DATA_WIDTH-1:0]       ram_data_a,
  output logic [DATA_WIDTH-1:0]       ram_data_b,
  input  logic [DATA_WIDTH-1:0]       ram_q_a,
  input  logic [DATA_WIDTH-1:0]       ram_q_b
);

  logic [ADDR_WIDTH-1:0] w_addr    [N_REQ];
  logic [DATA_WIDTH-1:0] w_wdata   [N_REQ];
  logic [DATA_WIDTH-1:0] w_rdata   [N_REQ];
  logic [DATA_WIDTH-1:0] r_rdata   [N_REQ];
  logic [DATA_WIDTH-1:0] w_q       [2];

  logic [IDX_W-1:0]      r_ptr;
  logic [IDX_W-1:0]      w_ptr_nxt;
  logic [IDX_W-1:0]      w_last;
  logic [N_REQ-1:0]      w_mask_a;
  logic [N_REQ-1:0]      w_mask_b;
  logic                  w_found_a;
  logic                  w_found_b;
  logic [IDX_W-1:0]      w_idx_a;
  logic [IDX_W-1:0]      w_idx_b;

  logic                  w_vld     [2];
  logic [IDX_W-1:0]      w_idx     [2];
  logic                  r_rd_vld  [2];
  logic [IDX_W-1:0]      r_rd_idx  [2];

  // Unpack the flattened per-requester buses.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_addr[gi]                           = addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata[gi]                          = wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    assign rdata[gi*DATA_WIDTH +: DATA_WIDTH]   = w_rdata[gi];
  end

  assign w_mask_a = '1;

  rr_pick #(.N_REQ(N_REQ)) u_pick_a (
    .i_req   (req),
    .i_mask  (w_mask_a),
    .i_ptr   (r_ptr),
    .o_found (w_found_a),
    .o_idx   (w_idx_a)
  );

  // Port B candidates: everyone except A, and except writes colliding with A's write address.
  always_comb begin
    w_mask_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_mask_b[i] = (IDX_W'(i) != w_idx_a) &&
                    !(we[w_idx_a] && we[i] && (w_addr[i] == w_addr[w_idx_a]));
    end
  end

  rr_pick #(.N_REQ(N_REQ)) u_pick_b (
    .i_req   (req),
    .i_mask  (w_mask_b),
    .i_ptr   (r_ptr),
    .o_found (w_found_b),
    .o_idx   (w_idx_b)
  );

  // Per-port grant qualification; reset suppresses all grants.
  always_comb begin
    w_vld[PORT_A] = w_found_a & ~rst;
    w_vld[PORT_B] = w_found_a & w_found_b & ~rst;
    w_idx[PORT_A] = w_idx_a;
    w_idx[PORT_B] = w_idx_b;
  end

  // One-hot grant per port.
  always_comb begin
    gnt = '0;
    for (int p = 0; p < 2; p++) begin
      if (w_vld[p]) gnt[w_idx[p]] = 1'b1;
    end
  end

  // RAM port drive; idle ports present a zero address and no write.
  always_comb begin
    ram_ce     = w_vld[PORT_A] | w_vld[PORT_B];
    ram_we_a   = w_vld[PORT_A] & we[w_idx[PORT_A]];
    ram_we_b   = w_vld[PORT_B] & we[w_idx[PORT_B]];
    ram_addr_a = w_vld[PORT_A] ? w_addr[w_idx[PORT_A]]  : '0;
    ram_addr_b = w_vld[PORT_B] ? w_addr[w_idx[PORT_B]]  : '0;
    ram_data_a = w_vld[PORT_A] ? w_wdata[w_idx[PORT_A]] : '0;
    ram_data_b = w_vld[PORT_B] ? w_wdata[w_idx[PORT_B]] : '0;
  end

  // Next pointer: one past the last granted index (B if present, else A).
  always_comb begin
    w_last    = w_vld[PORT_B] ? w_idx[PORT_B] : w_idx[PORT_A];
    w_ptr_nxt = r_ptr;
    if (w_vld[PORT_A]) begin
      w_ptr_nxt = (w_last == IDX_W'(N_REQ - 1)) ? '0 : w_last + IDX_W'(1);
    end
  end

  // Pointer and read-return bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      for (int p = 0; p < 2; p++) begin
        r_rd_vld[p] <= 1'b0;
        r_rd_idx[p] <= '0;
      end
    end else begin
      r_ptr <= w_ptr_nxt;
      for (int p = 0; p < 2; p++) begin
        r_rd_vld[p] <= w_vld[p] & ~we[w_idx[p]];
        r_rd_idx[p] <= w_idx[p];
      end
    end
  end

  assign w_q[PORT_A] = ram_q_a;
  assign w_q[PORT_B] = ram_q_b;

  // Route RAM read data to the owning requester; other slices hold their last value.
  always_comb begin
    rvalid = '0;
    for (int i = 0; i < N_REQ; i++) w_rdata[i] = r_rdata[i];
    for (int p = 0; p < 2; p++) begin
      if (r_rd_vld[p]) begin
        rvalid[r_rd_idx[p]]  = 1'b1;
        w_rdata[r_rd_idx[p]] = w_q[p];
      end
    end
  end

  // Hold register behind each rdata slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) r_rdata[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) r_rdata[i] <= w_rdata[i];
    end
  end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Scoreboard bench for dpram_port_arbiter with a behavioural RAM and reference model.
module tb_dpram_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 3;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, we, gnt, rvalid;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata, rdata;
  logic            ram_ce, ram_we_a, ram_we_b;
  logic [AW-1:0]   ram_addr_a, ram_addr_b;
  logic [DW-1:0]   ram_data_a, ram_data_b, ram_q_a, ram_q_b;

  // Requester-side stimulus state
  logic [N-1:0]    t_req, t_we;
  logic [AW-1:0]   t_addr [N];
  logic [DW-1:0]   t_wd   [N];

  // Reference model state
  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t            exp_q [$];
  exp_t            tmp_q [$];
  logic [DW-1:0]   ref_mem [8];
  logic [DW-1:0]   m_rdata [N];
  int              m_ptr;
  int              cyc = 0;
  bit              mon_en = 1'b0;
  int              n_chk = 0;
  int              n_pass = 0;

  dpram_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .ram_ce     (ram_ce),
    .ram_we_a   (ram_we_a),
    .ram_we_b   (ram_we_b),
    .ram_addr_a (ram_addr_a),
    .ram_addr_b (ram_addr_b),
    .ram_data_a (ram_data_a),
    .ram_data_b (ram_data_b),
    .ram_q_a    (ram_q_a),
    .ram_q_b    (ram_q_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    req = t_req;
    we  = t_we;
    for (int i = 0; i < N; i++) begin
      addr[i*AW +: AW]  = t_addr[i];
      wdata[i*DW +: DW] = t_wd[i];
    end
  end

  // Behavioural dual-port RAM: registered read, read-before-write
  logic [DW-1:0] ram_mem [8];
  always @(posedge clk) begin
    if (ram_ce) begin
      ram_q_a <= ram_mem[ram_addr_a];
      ram_q_b <= ram_mem[ram_addr_b];
      if (ram_we_a) ram_mem[ram_addr_a] <= ram_data_a;
      if (ram_we_b) ram_mem[ram_addr_b] <= ram_data_b;
    end
  end

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    else
      n_pass++;
  endfunction

  // Reference model for one cycle: predicted grants, RAM drive, queued read responses
  task automatic model_cycle(output logic [N-1:0] g);
    int a, b, i;
    bit ha, hb;
    logic [N-1:0] eg;
    ha = 1'b0; hb = 1'b0; a = 0; b = 0; eg = '0;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (t_req[i]) begin
          if (!ha) begin
            ha = 1'b1; a = i;
          end else if (!hb && !(t_we[a] && t_we[i] && t_addr[a] == t_addr[i])) begin
            hb = 1'b1; b = i;
          end
        end
      end
    end
    if (ha) eg[a] = 1'b1;
    if (hb) eg[b] = 1'b1;
    chk("gnt",        64'(gnt),        64'(eg));
    chk("ram_ce",     64'(ram_ce),     64'(ha));
    chk("ram_we_a",   64'(ram_we_a),   64'(ha && t_we[a]));
    chk("ram_we_b",   64'(ram_we_b),   64'(hb && t_we[b]));
    chk("ram_addr_a", 64'(ram_addr_a), ha ? 64'(t_addr[a]) : 64'd0);
    chk("ram_addr_b", 64'(ram_addr_b), hb ? 64'(t_addr[b]) : 64'd0);
    if (ha && t_we[a]) chk("ram_data_a", 64'(ram_data_a), 64'(t_wd[a]));
    if (hb && t_we[b]) chk("ram_data_b", 64'(ram_data_b), 64'(t_wd[b]));
    if (ha && !t_we[a]) exp_q.push_back('{idx: a, data: ref_mem[t_addr[a]], due: cyc + 1});
    if (hb && !t_we[b]) exp_q.push_back('{idx: b, data: ref_mem[t_addr[b]], due: cyc + 1});
    if (ha && t_we[a]) ref_mem[t_addr[a]] = t_wd[a];
    if (hb && t_we[b]) ref_mem[t_addr[b]] = t_wd[b];
    if (rst)     m_ptr = 0;
    else if (ha) m_ptr = ((hb ? b : a) + 1) % N;
    g = eg;
  endtask

  // Monitor: compare rvalid/rdata against responses due this cycle
  logic [N-1:0]    mon_rv;
  logic [N*DW-1:0] mon_rd;
  always @(negedge clk) begin
    if (mon_en) begin
      mon_rv = '0;
      foreach (exp_q[j]) begin
        if (exp_q[j].due == cyc) begin
          mon_rv[exp_q[j].idx]  = 1'b1;
          m_rdata[exp_q[j].idx] = exp_q[j].data;
        end
      end
      for (int i = 0; i < N; i++) mon_rd[i*DW +: DW] = m_rdata[i];
      chk("rvalid", 64'(rvalid), 64'(mon_rv));
      chk("rdata",  64'(rdata),  64'(mon_rd));
      tmp_q.delete();
      foreach (exp_q[j]) if (exp_q[j].due > cyc) tmp_q.push_back(exp_q[j]);
      exp_q = tmp_q;
      if (rst) for (int i = 0; i < N; i++) m_rdata[i] = '0;
    end
  end

  task automatic step();
    logic [N-1:0] g;
    @(negedge clk);
    model_cycle(g);
    @(posedge clk);
    #1;
    t_req = t_req & ~g;
  endtask

  task automatic set_rq(input int i, input bit w, input int a, input int d);
    t_req[i]  = 1'b1;
    t_we[i]   = w;
    t_addr[i] = AW'(a);
    t_wd[i]   = DW'(d);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (t_req != '0 && n < 20) begin
      step();
      n++;
    end
    chk("drain_done", 64'(t_req), 64'd0);
    step();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    t_req = '0;
    t_we  = '0;
    for (int i = 0; i < N; i++) begin
      t_addr[i]  = '0;
      t_wd[i]    = '0;
      m_rdata[i] = '0;
    end
    m_ptr = 0;
    step();
    step();
    rst = 1'b0;
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rdata",  64'(rdata),  64'd0);
    mon_en = 1'b1;

    // Clear RAM through the arbiter, two writes per cycle
    for (int a = 0; a < 8; a += 2) begin
      set_rq(0, 1'b1, a, 0);
      set_rq(1, 1'b1, a + 1, 0);
      drain();
    end
    set_rq(0, 1'b1, 5, 8'h3C);
    drain();

    // Single requester read after reset
    pulse_reset();
    set_rq(2, 1'b0, 5, 0);
    drain();
    // ptr is now 3: 3 wins A, 0 wins B
    for (int i = 0; i < N; i++) set_rq(i, 1'b0, i, 0);
    drain();

    // Dual grant with rotation from ptr 0
    pulse_reset();
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < N; i++) if (!t_req[i]) set_rq(i, 1'b0, i, 0);
      step();
    end
    drain();

    // Write-write same-address conflict
    pulse_reset();
    set_rq(0, 1'b1, 3, 8'hAA);
    set_rq(1, 1'b1, 3, 8'h55);
    drain();
    set_rq(2, 1'b0, 3, 0);
    drain();

    // Read and write to the same address in one cycle
    pulse_reset();
    set_rq(0, 1'b1, 2, 8'h11);
    set_rq(1, 1'b0, 2, 0);
    drain();
    set_rq(2, 1'b0, 2, 0);
    drain();

    // Reset asserted in the cycle a read is requested
    set_rq(0, 1'b0, 4, 0);
    rst = 1'b1;
    step();
    rst   = 1'b0;
    t_req = '0;
    step();
    set_rq(1, 1'b0, 6, 0);
    set_rq(3, 1'b0, 7, 0);
    drain();

    // Randomized traffic with occasional reset
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!t_req[i] && $urandom_range(0, 1) == 1)
          set_rq(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      end
      rst = ($urandom_range(0, 99) == 0);
      step();
      rst = 1'b0;
    end
    t_req = '0;
    step();
    step();
    step();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
